// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmitter
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  localparam int DEFAULT_CLKS_PER_BIT = 868;
  localparam int DATA_BITS            = 8;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - show-ahead synchronous FIFO with registered status flags
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             r_full;
  logic             r_empty;
  logic             w_push_ok;
  logic             w_pop_ok;
  logic [LW-1:0]    w_level_next;

  // Gating uses the flags as they stood at the start of the cycle.
  assign w_push_ok = push & ~r_full;
  assign w_pop_ok  = pop & ~r_empty;

  always_comb begin
    w_level_next = r_level;
    if (w_push_ok && !w_pop_ok) begin
      w_level_next = r_level + 1'b1;
    end else if (!w_push_ok && w_pop_ok) begin
      w_level_next = r_level - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level <= w_level_next;
      r_full  <= (w_level_next == LW'(DEPTH));
      r_empty <= (w_level_next == '0);
    end
  end

  assign dout  = r_mem[r_rd_ptr];
  assign full  = r_full;
  assign empty = r_empty;
  assign level = r_level;

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - FIFO-buffered 8N1 serial transmitter with sticky overflow
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 16,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 clr_ovf,
  output logic                 tx_o,
  output logic                 fifo_full,
  output logic                 fifo_empty,
  output logic                 busy,
  output logic [LW-1:0]        level,
  output logic                 overflow
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] BIT_LAST  = IW'(DATA_BITS - 1);

  uart_state_t          r_state, w_state_next;
  logic [BW-1:0]        r_baud, w_baud_next;
  logic [IW-1:0]        r_bit_idx, w_bit_idx_next;
  logic [DATA_BITS-1:0] r_shift, w_shift_next;
  logic                 r_tx, w_tx_next;
  logic                 r_busy;
  logic                 r_ovf;
  logic                 w_pop;
  logic                 w_baud_end;
  logic [DATA_BITS-1:0] w_fifo_dout;

  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_en),
    .pop   (w_pop),
    .din   (wr_data),
    .dout  (w_fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  assign w_baud_end = (r_baud == BAUD_LAST);

  always_comb begin
    w_state_next   = r_state;
    w_baud_next    = r_baud;
    w_bit_idx_next = r_bit_idx;
    w_shift_next   = r_shift;
    w_pop          = 1'b0;
    case (r_state)
      IDLE: begin
        if (!fifo_empty) begin
          w_pop          = 1'b1;
          w_shift_next   = w_fifo_dout;
          w_bit_idx_next = '0;
          w_baud_next    = '0;
          w_state_next   = START;
        end
      end
      START: begin
        if (w_baud_end) begin
          w_baud_next  = '0;
          w_state_next = DATA;
        end else begin
          w_baud_next = r_baud + 1'b1;
        end
      end
      DATA: begin
        if (w_baud_end) begin
          w_baud_next = '0;
          if (r_bit_idx == BIT_LAST) begin
            w_state_next = STOP;
          end else begin
            w_shift_next   = r_shift >> 1;
            w_bit_idx_next = r_bit_idx + 1'b1;
          end
        end else begin
          w_baud_next = r_baud + 1'b1;
        end
      end
      STOP: begin
        if (w_baud_end) begin
          w_baud_next = '0;
          // Chain straight into the next start bit so queued bytes leave with no idle gap.
          if (!fifo_empty) begin
            w_pop          = 1'b1;
            w_shift_next   = w_fifo_dout;
            w_bit_idx_next = '0;
            w_state_next   = START;
          end else begin
            w_state_next = IDLE;
          end
        end else begin
          w_baud_next = r_baud + 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase

    // Line level is derived from the next state so tx_o itself can be a flop.
    case (w_state_next)
      START:   w_tx_next = 1'b0;
      DATA:    w_tx_next = w_shift_next[0];
      default: w_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_baud    <= w_baud_next;
      r_bit_idx <= w_bit_idx_next;
      r_shift   <= w_shift_next;
      r_tx      <= w_tx_next;
      r_busy    <= (w_state_next != IDLE);
      if (wr_en && fifo_full) begin
        r_ovf <= 1'b1;
      end else if (clr_ovf) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign tx_o     = r_tx;
  assign busy     = r_busy;
  assign overflow = r_ovf;

endmodule
